rtc_access_sched: RTL

//  Schedules all traffic to the PCF8563 through one shared I2C transaction engine.

---
 rtl/rtc_access_sched_pkg.sv | 24 ++
 rtl/rtc_access_sched_if.sv | 25 ++
 rtl/rtc_access_sched_poll_timer.sv | 29 ++
 rtl/rtc_access_sched.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rtc_access_sched_pkg.sv
// Shared constants and types for the PCF8563 access scheduler.
// Register map, transfer lengths, FSM state and grant encodings, read-data masking.
package rtc_pkg;

  localparam logic [7:0] REG_TIME = 8'h02;
  localparam logic [7:0] REG_DATE = 8'h05;
  localparam logic [2:0] LEN_TIME = 3'd3;
  localparam logic [2:0] LEN_DATE = 3'd4;
  localparam logic [2:0] LEN_READ = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_TIME, G_DATE, G_READ} grant_t;

  // Strips VL (sec[7]) and unused hour/min bits; result is {hour,min,sec}.
  function automatic logic [23:0] mask_time(input logic [55:0] rd);
    return {rd[23:16] & 8'h3F, rd[15:8] & 8'h7F, rd[7:0] & 8'h7F};
  endfunction

  // Strips century (month[7]) and unused bits; result is {year,month,weekday,day}.
  function automatic logic [31:0] mask_date(input logic [55:0] rd);
    return {rd[55:48], rd[47:40] & 8'h1F, rd[39:32] & 8'h07, rd[31:24] & 8'h3F};
  endfunction

endpackage

// File: rtl/rtc_access_sched_if.sv
// Command/response link between the scheduler (master) and the I2C transaction engine (slave).
// One command in flight; cmd_valid/cmd_ready handshake, rsp_done is a single-cycle completion pulse.
interface rtc_access_sched_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        rsp_done;
  logic        rsp_err;
  logic [55:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_wdata,
    input  cmd_ready, rsp_done, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, cmd_wdata,
    output cmd_ready, rsp_done, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/rtc_access_sched_poll_timer.sv
// Free-running 0..POLL_CYC-1 counter; tick is high for the single cycle the count sits at its top value.
// Latency: tick every POLL_CYC cycles after reset; no backpressure, ticks are never held.
module rtc_poll_timer #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int POLL_MS  = 500
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int POLL_CYC = CLK_FREQ / 1000 * POLL_MS;
  localparam int CW       = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(POLL_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rtc_access_sched.sv
// Arbitrates time-set, date-set and periodic reads onto one I2C engine; publishes decoded time/date.
// Command issued 1 cycle after the IDLE decision; fields held while cmd_ready is low; WAIT aborts after TIMEOUT_CYC.
module rtc_access_sched
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int POLL_MS     = 500,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_time,
  input  logic               set_date,
  input  logic [23:0]        time_2_set,
  input  logic [31:0]        date_2_set,
  output logic               set_done,
  rtc_access_sched_if.master eng,
  output logic [23:0]        cur_time,
  output logic [31:0]        cur_date,
  output logic               rd_valid,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t        state_q, state_d;
  grant_t        grant_q;
  logic          err_q;
  logic          rd_pend;
  logic          tick;
  logic          timeout;
  logic          cmd_valid;
  logic [TW-1:0] wait_cnt;
  logic          cmd_wr_q;
  logic [7:0]    cmd_addr_q;
  logic [2:0]    cmd_len_q;
  logic [31:0]   cmd_wdata_q;

  rtc_poll_timer #(
    .CLK_FREQ (CLK_FREQ),
    .POLL_MS  (POLL_MS)
  ) u_poll (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign timeout       = (wait_cnt == TW'(TIMEOUT_CYC - 1));
  assign eng.cmd_valid = cmd_valid;
  assign eng.cmd_wr    = cmd_wr_q;
  assign eng.cmd_addr  = cmd_addr_q;
  assign eng.cmd_len   = cmd_len_q;
  assign eng.cmd_wdata = cmd_wdata_q;

  always_comb begin
    state_d   = state_q;
    cmd_valid = 1'b0;
    busy      = 1'b1;
    set_done  = 1'b0;
    rd_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (set_time || set_date || rd_pend) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (eng.cmd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng.rsp_done || timeout) state_d = S_DONE;
      end
      S_DONE: begin
        set_done = (grant_q != G_READ);
        rd_valid = (grant_q == G_READ) && !err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= G_TIME;
      err_q       <= 1'b0;
      rd_pend     <= 1'b0;
      wait_cnt    <= '0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      cmd_wdata_q <= '0;
      cur_time    <= '0;
      cur_date    <= '0;
      err_cnt     <= '0;
    end else begin
      state_q <= state_d;
      // A fresh tick wins over the clear so a read completing on a tick still schedules the next one.
      rd_pend <= tick | (rd_pend & ~rd_valid);

      if (state_q == S_IDLE) begin
        if (set_time) begin
          grant_q     <= G_TIME;
          cmd_wr_q    <= 1'b1;
          cmd_addr_q  <= REG_TIME;
          cmd_len_q   <= LEN_TIME;
          cmd_wdata_q <= {8'h00, time_2_set};
        end else if (set_date) begin
          grant_q     <= G_DATE;
          cmd_wr_q    <= 1'b1;
          cmd_addr_q  <= REG_DATE;
          cmd_len_q   <= LEN_DATE;
          cmd_wdata_q <= date_2_set;
        end else if (rd_pend) begin
          grant_q     <= G_READ;
          cmd_wr_q    <= 1'b0;
          cmd_addr_q  <= REG_TIME;
          cmd_len_q   <= LEN_READ;
          cmd_wdata_q <= '0;
        end
      end

      if (state_q == S_WAIT) wait_cnt <= wait_cnt + TW'(1);
      else                   wait_cnt <= '0;

      // rsp_rdata is only valid alongside rsp_done, so capture it on the way into DONE.
      if (state_q == S_WAIT && state_d == S_DONE) begin
        err_q <= eng.rsp_done ? eng.rsp_err : 1'b1;
        if (grant_q == G_READ && eng.rsp_done && !eng.rsp_err) begin
          cur_time <= mask_time(eng.rsp_rdata);
          cur_date <= mask_date(eng.rsp_rdata);
        end
      end

      if (state_q == S_DONE && err_q && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
